sim_dtm: RTL and testbench
==========================

SIM_DTM -- requirements
Module: sim_dtm

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the max cycles a transaction may spend waiting on the debug module before abort; legal range 2..65535.
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 host_req_valid  input  1  SHALL indicate a host command is offered.
REQ-005 host_req_ready  output  1  SHALL indicate the block accepts a host command.
REQ-006 host_req_addr  input  7  SHALL carry the DMI register address.
REQ-007 host_req_op  input  2  SHALL carry the opcode: 0 nop, 1 read, 2 write, 3 exit.
REQ-008 host_req_data  input  32  SHALL carry write data, or the exit code for op 3.
REQ-009 host_resp_valid  output  1  SHALL indicate a host response is presented.
REQ-010 host_resp_ready  input  1  SHALL indicate the host takes the response.
REQ-011 host_resp_resp  output  2  SHALL carry the DMI status: 0 ok, 2 failed, 3 busy.
REQ-012 host_resp_data  output  32  SHALL carry the DMI read data.
REQ-013 debug_req_valid  output  1  SHALL indicate a DMI request to the debug module.
REQ-014 debug_req_ready  input  1  SHALL indicate the debug module accepts the request.
REQ-015 debug_req_bits_addr  output  7  SHALL carry the DMI request address.
REQ-016 debug_req_bits_op  output  2  SHALL carry the DMI request opcode.
REQ-017 debug_req_bits_data  output  32  SHALL carry the DMI request data.
REQ-018 debug_resp_valid  input  1  SHALL indicate a DMI response is offered.
REQ-019 debug_resp_ready  output  1  SHALL indicate the block accepts a DMI response.
REQ-020 debug_resp_bits_resp  input  2  SHALL carry the DMI response status.
REQ-021 debug_resp_bits_data  input  32  SHALL carry the DMI response data.
REQ-022 exit  output  32  SHALL be the simulation exit word; 0 means running.

Function
REQ-023 FSM states SHALL be IDLE, REQ, RESP, HRESP, DONE.
REQ-024 IDLE: host_req_ready=1; all other valid/ready outputs SHALL be 0.
REQ-025 IDLE, handshake with op 0/1/2: latch addr/op/data, clear timeout counter, next state REQ.
REQ-026 IDLE, handshake with op 3: exit <= {host_req_data[30:0],1'b1}, next state DONE; no DMI request is issued.
REQ-027 REQ: debug_req_valid=1, and debug_req_bits_* SHALL hold the latched values stable. On debug_req_ready, clear the counter and go to RESP.
REQ-028 RESP: debug_resp_ready=1. On debug_resp_valid, latch resp/data into host_resp_* and go to HRESP.
REQ-029 Latency: host accept in cycle N -> debug_req_valid in N+1. DMI response in cycle M -> host_resp_valid in M+1.
REQ-030 Timeout: the counter SHALL increment each cycle in REQ or RESP without a completing handshake. On reaching TIMEOUT_CYCLES: host_resp_resp=2, host_resp_data=0, go to HRESP, with debug_req_valid/debug_resp_ready low from the next cycle.
REQ-031 A handshake in the same cycle the counter reaches TIMEOUT_CYCLES SHALL take priority over the timeout.
REQ-032 HRESP: host_resp_valid=1 with stable data. On host_resp_ready, go to IDLE. host_req_ready SHALL stay 0 until IDLE.
REQ-033 DMI status 3 (busy) SHALL be forwarded unchanged; the host handles retry.
REQ-034 DONE: all valid/ready outputs 0; exit SHALL stay constant until reset; inputs are ignored.
REQ-035 Only one transaction SHALL be outstanding at a time.

Reset
REQ-036 While rst_ni=0: state IDLE; exit=0; host_resp_*=0; latched request fields=0; counter=0; all valid/ready outputs 0 except host_req_ready, which is 1 after reset release.
REQ-037 Reset asserted mid-transaction SHALL abort it immediately, with no host response produced.

Verification
REQ-038 Host write addr 0x10, data 0x1, debug_req_ready tied 1, response ok after 2 cycles -> one debug request {0x10,2,0x1}; host_resp resp=0.
REQ-039 Host read addr 0x11, debug returns data 0xDEADBEEF, status 0 -> host_resp_data=0xDEADBEEF, resp=0, host_resp_valid one cycle after the DMI response.
REQ-040 debug_req_ready held 0 with TIMEOUT_CYCLES=8 -> host_resp resp=2, data=0 after 8 cycles in REQ; the block then returns to IDLE.
REQ-041 Host op 3, data 5 -> exit=0x0000000B, held; later host commands are not accepted.
REQ-042 host_resp_ready held 0 for 5 cycles -> host_resp_valid and data remain stable; host_req_ready=0 throughout.
REQ-043 rst_ni pulsed low while in RESP -> all outputs return to reset values, exit=0, next command is accepted normally.

Source files
------------

// File: rtl/sim_dtm.sv
// sim_dtm: bridges a simple host command port to a DMI debug-module port.
// One transaction is in flight at a time. Host reads, writes and nops are
// forwarded to the debug module; the DMI response is returned to the host.
// A host "exit" command (op 3) latches an exit word and freezes the block
// until reset. A waiting transaction that stalls for TIMEOUT_CYCLES cycles
// is aborted with status 2 (failed) and data 0.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   host_req_*                host command (valid/ready, addr, op, data)
//   host_resp_*               host response (valid/ready, resp, data)
//   debug_req_*               DMI request to the debug module
//   debug_resp_*              DMI response from the debug module
//   exit                      exit word, 0 while running
//   dbg_state_o               current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer keeps valid high and its payload stable until the
// transfer; valid never depends on ready.
module sim_dtm #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        host_req_valid,
    output logic        host_req_ready,
    input  logic [6:0]  host_req_addr,
    input  logic [1:0]  host_req_op,
    input  logic [31:0] host_req_data,
    output logic        host_resp_valid,
    input  logic        host_resp_ready,
    output logic [1:0]  host_resp_resp,
    output logic [31:0] host_resp_data,
    output logic        debug_req_valid,
    input  logic        debug_req_ready,
    output logic [6:0]  debug_req_bits_addr,
    output logic [1:0]  debug_req_bits_op,
    output logic [31:0] debug_req_bits_data,
    input  logic        debug_resp_valid,
    output logic        debug_resp_ready,
    input  logic [1:0]  debug_resp_bits_resp,
    input  logic [31:0] debug_resp_bits_data,
    output logic [31:0] exit,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RESP  = 3'd2,
        HRESP = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam logic [1:0]  OP_EXIT     = 2'd3;
    localparam logic [1:0]  RESP_FAILED = 2'd2;
    localparam logic [15:0] CNT_LIMIT   = 16'(TIMEOUT_CYCLES);

    state_e      state_q;
    logic [6:0]  addr_q;
    logic [1:0]  op_q;
    logic [31:0] wdata_q;
    logic [1:0]  resp_q;
    logic [31:0] rdata_q;
    logic [31:0] exit_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        host_req_ready_q;
    logic        host_resp_valid_q;
    logic        debug_req_valid_q;
    logic        debug_resp_ready_q;
    logic        cnt_expired;

    // The counter "reaches" the limit when the value it would take this
    // cycle equals TIMEOUT_CYCLES; a handshake in that cycle still wins.
    assign cnt_d       = cnt_q + 16'd1;
    assign cnt_expired = (cnt_d == CNT_LIMIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q            <= IDLE;
            addr_q             <= '0;
            op_q               <= '0;
            wdata_q            <= '0;
            resp_q             <= '0;
            rdata_q            <= '0;
            exit_q             <= '0;
            cnt_q              <= '0;
            host_req_ready_q   <= 1'b1;
            host_resp_valid_q  <= 1'b0;
            debug_req_valid_q  <= 1'b0;
            debug_resp_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (host_req_valid && host_req_ready_q) begin
                        host_req_ready_q <= 1'b0;
                        if (host_req_op == OP_EXIT) begin
                            // Bit 0 forced high so any exit code reads non-zero.
                            exit_q  <= {host_req_data[30:0], 1'b1};
                            state_q <= DONE;
                        end else begin
                            addr_q            <= host_req_addr;
                            op_q              <= host_req_op;
                            wdata_q           <= host_req_data;
                            cnt_q             <= '0;
                            debug_req_valid_q <= 1'b1;
                            state_q           <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (debug_req_ready) begin
                        cnt_q              <= '0;
                        debug_req_valid_q  <= 1'b0;
                        debug_resp_ready_q <= 1'b1;
                        state_q            <= RESP;
                    end else if (cnt_expired) begin
                        cnt_q             <= cnt_d;
                        resp_q            <= RESP_FAILED;
                        rdata_q           <= '0;
                        debug_req_valid_q <= 1'b0;
                        host_resp_valid_q <= 1'b1;
                        state_q           <= HRESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                RESP: begin
                    if (debug_resp_valid) begin
                        // Busy (3) and every other status pass through untouched.
                        resp_q             <= debug_resp_bits_resp;
                        rdata_q            <= debug_resp_bits_data;
                        debug_resp_ready_q <= 1'b0;
                        host_resp_valid_q  <= 1'b1;
                        state_q            <= HRESP;
                    end else if (cnt_expired) begin
                        cnt_q              <= cnt_d;
                        resp_q             <= RESP_FAILED;
                        rdata_q            <= '0;
                        debug_resp_ready_q <= 1'b0;
                        host_resp_valid_q  <= 1'b1;
                        state_q            <= HRESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HRESP: begin
                    if (host_resp_ready) begin
                        host_resp_valid_q <= 1'b0;
                        host_req_ready_q  <= 1'b1;
                        state_q           <= IDLE;
                    end
                end
                DONE: begin
                    // Terminal until reset; every input is ignored.
                end
                default: begin
                    host_req_ready_q   <= 1'b1;
                    host_resp_valid_q  <= 1'b0;
                    debug_req_valid_q  <= 1'b0;
                    debug_resp_ready_q <= 1'b0;
                    state_q            <= IDLE;
                end
            endcase
        end
    end

    assign host_req_ready      = host_req_ready_q;
    assign host_resp_valid     = host_resp_valid_q;
    assign host_resp_resp      = resp_q;
    assign host_resp_data      = rdata_q;
    assign debug_req_valid     = debug_req_valid_q;
    assign debug_req_bits_addr = addr_q;
    assign debug_req_bits_op   = op_q;
    assign debug_req_bits_data = wdata_q;
    assign debug_resp_ready    = debug_resp_ready_q;
    assign exit                = exit_q;
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_sim_dtm.sv
module tb_sim_dtm;

    localparam int T = 8;

    logic        clk_i;
    logic        rst_ni;
    logic        host_req_valid;
    logic        host_req_ready;
    logic [6:0]  host_req_addr;
    logic [1:0]  host_req_op;
    logic [31:0] host_req_data;
    logic        host_resp_valid;
    logic        host_resp_ready;
    logic [1:0]  host_resp_resp;
    logic [31:0] host_resp_data;
    logic        debug_req_valid;
    logic        debug_req_ready;
    logic [6:0]  debug_req_bits_addr;
    logic [1:0]  debug_req_bits_op;
    logic [31:0] debug_req_bits_data;
    logic        debug_resp_valid;
    logic        debug_resp_ready;
    logic [1:0]  debug_resp_bits_resp;
    logic [31:0] debug_resp_bits_data;
    logic [31:0] exit_w;
    logic [2:0]  dbg_state;

    sim_dtm #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .host_req_valid       (host_req_valid),
        .host_req_ready       (host_req_ready),
        .host_req_addr        (host_req_addr),
        .host_req_op          (host_req_op),
        .host_req_data        (host_req_data),
        .host_resp_valid      (host_resp_valid),
        .host_resp_ready      (host_resp_ready),
        .host_resp_resp       (host_resp_resp),
        .host_resp_data       (host_resp_data),
        .debug_req_valid      (debug_req_valid),
        .debug_req_ready      (debug_req_ready),
        .debug_req_bits_addr  (debug_req_bits_addr),
        .debug_req_bits_op    (debug_req_bits_op),
        .debug_req_bits_data  (debug_req_bits_data),
        .debug_resp_valid     (debug_resp_valid),
        .debug_resp_ready     (debug_resp_ready),
        .debug_resp_bits_resp (debug_resp_bits_resp),
        .debug_resp_bits_data (debug_resp_bits_data),
        .exit                 (exit_w),
        .dbg_state_o          (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [33:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [6:0]  addr;
        logic [31:0] data;
        int          req_wait;
        int          resp_wait;
        logic [1:0]  d_resp;
        logic [31:0] d_data;
        int          hold;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    // Reference: a transaction fails with {2,0} if either side stalls for
    // T or more cycles; otherwise the DMI status/data come back verbatim.
    function automatic logic [33:0] ref_resp(input int req_wait, input int resp_wait,
                                             input logic [1:0] r, input logic [31:0] d);
        if (req_wait >= T) return {2'd2, 32'd0};
        if (resp_wait >= T) return {2'd2, 32'd0};
        return {r, d};
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle. req_wait/resp_wait are the
    // number of cycles the debug side stalls before completing each phase.
    task automatic run_txn(input vec_t v);
        logic [33:0] e;
        logic        req_to;
        logic        resp_to;
        int          n;
        req_to  = (v.req_wait >= T);
        resp_to = !req_to && (v.resp_wait >= T);
        exp_q.push_back({v.exp_resp, v.exp_data});

        chk("idle_req_ready", 64'(host_req_ready), 64'd1);
        host_req_valid = 1'b1;
        host_req_op    = v.op;
        host_req_addr  = v.addr;
        host_req_data  = v.data;
        tick();
        host_req_valid = 1'b0;
        host_req_addr  = 7'($urandom);
        host_req_data  = $urandom;
        host_req_op    = 2'($urandom_range(0, 3));

        n = req_to ? T : v.req_wait + 1;
        for (int c = 0; c < n; c++) begin
            chk("req_valid", 64'(debug_req_valid), 64'd1);
            chk("req_bits", 64'({debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data}),
                64'({v.addr, v.op, v.data}));
            chk("req_host_ready_low", 64'(host_req_ready), 64'd0);
            chk("req_resp_ready_low", 64'(debug_resp_ready), 64'd0);
            debug_req_ready = !req_to && (c == v.req_wait);
            tick();
        end
        debug_req_ready = 1'b0;

        if (!req_to) begin
            n = resp_to ? T : v.resp_wait + 1;
            for (int c = 0; c < n; c++) begin
                chk("resp_ready", 64'(debug_resp_ready), 64'd1);
                chk("resp_req_valid_low", 64'(debug_req_valid), 64'd0);
                if (!resp_to && c == v.resp_wait) begin
                    debug_resp_valid     = 1'b1;
                    debug_resp_bits_resp = v.d_resp;
                    debug_resp_bits_data = v.d_data;
                end else begin
                    debug_resp_valid     = 1'b0;
                    debug_resp_bits_resp = 2'($urandom);
                    debug_resp_bits_data = $urandom;
                end
                tick();
            end
            debug_resp_valid     = 1'b0;
            debug_resp_bits_resp = 2'($urandom);
            debug_resp_bits_data = $urandom;
        end

        chk("hresp_dbg_idle", 64'({debug_req_valid, debug_resp_ready}), 64'd0);
        e = exp_q.pop_front();
        for (int h = 0; h <= v.hold; h++) begin
            chk("hresp_valid", 64'(host_resp_valid), 64'd1);
            chk("hresp_payload", 64'({host_resp_resp, host_resp_data}), 64'(e));
            chk("hresp_req_ready_low", 64'(host_req_ready), 64'd0);
            host_resp_ready = (h == v.hold);
            tick();
        end
        host_resp_ready = 1'b0;
        chk("back_idle", 64'({host_resp_valid, host_req_ready}), 64'b01);
    endtask

    task automatic send_exit(input logic [31:0] code, input logic [31:0] exp_exit);
        chk("exit_req_ready", 64'(host_req_ready), 64'd1);
        host_req_valid = 1'b1;
        host_req_op    = 2'd3;
        host_req_data  = code;
        tick();
        chk("exit_word", 64'(exit_w), 64'(exp_exit));
        chk("exit_no_dmi", 64'({debug_req_valid, host_resp_valid, debug_resp_ready}), 64'd0);
        host_req_op = 2'd1;
        for (int i = 0; i < 6; i++) begin
            chk("done_req_ready_low", 64'(host_req_ready), 64'd0);
            chk("done_no_dmi", 64'({debug_req_valid, host_resp_valid, debug_resp_ready}), 64'd0);
            chk("done_exit_held", 64'(exit_w), 64'(exp_exit));
            host_req_data    = $urandom;
            host_req_op      = 2'($urandom_range(0, 3));
            debug_resp_valid = 1'($urandom);
            debug_req_ready  = 1'($urandom);
            tick();
        end
        host_req_valid   = 1'b0;
        debug_resp_valid = 1'b0;
        debug_req_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_reset_ready", 64'(host_req_ready), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        vec_t rv;
        logic [33:0] m;
        int sel;

        host_req_valid       = 1'b0;
        host_req_addr        = '0;
        host_req_op          = '0;
        host_req_data        = '0;
        host_resp_ready      = 1'b0;
        debug_req_ready      = 1'b0;
        debug_resp_valid     = 1'b0;
        debug_resp_bits_resp = '0;
        debug_resp_bits_data = '0;
        rst_ni               = 1'b0;

        //           op    addr    data          rqw rsw dresp  ddata          hold eresp  edata
        vecs[0] = '{2'd2, 7'h10, 32'h0000_0001, 0,  1,  2'd0, 32'h0000_0000, 0,   2'd0, 32'h0000_0000};
        vecs[1] = '{2'd1, 7'h11, 32'h0000_0000, 0,  0,  2'd0, 32'hDEAD_BEEF, 0,   2'd0, 32'hDEAD_BEEF};
        vecs[2] = '{2'd1, 7'h05, 32'h0000_0000, 2,  3,  2'd3, 32'h0000_1234, 1,   2'd3, 32'h0000_1234};
        vecs[3] = '{2'd2, 7'h20, 32'h1357_9BDF, 8,  0,  2'd0, 32'h0000_0000, 0,   2'd2, 32'h0000_0000};
        vecs[4] = '{2'd1, 7'h21, 32'h0000_0000, 7,  0,  2'd0, 32'hA5A5_A5A5, 0,   2'd0, 32'hA5A5_A5A5};
        vecs[5] = '{2'd1, 7'h22, 32'h0000_0000, 0,  8,  2'd0, 32'h1111_1111, 0,   2'd2, 32'h0000_0000};
        vecs[6] = '{2'd1, 7'h23, 32'h0000_0000, 1,  7,  2'd2, 32'h0000_0055, 2,   2'd2, 32'h0000_0055};
        vecs[7] = '{2'd1, 7'h7F, 32'h0000_0000, 0,  2,  2'd0, 32'hCAFE_F00D, 5,   2'd0, 32'hCAFE_F00D};
        vecs[8] = '{2'd0, 7'h00, 32'h0000_0000, 0,  0,  2'd0, 32'h0000_0000, 0,   2'd0, 32'h0000_0000};

        // Reset values while held in reset.
        tick();
        tick();
        chk("rst_exit", 64'(exit_w), 64'd0);
        chk("rst_host_resp", 64'({host_resp_valid, host_resp_resp, host_resp_data}), 64'd0);
        chk("rst_dbg_valids", 64'({debug_req_valid, debug_resp_ready}), 64'd0);
        chk("rst_req_bits", 64'({debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data}), 64'd0);
        rst_ni = 1'b1;
        tick();
        chk("post_reset_ready", 64'(host_req_ready), 64'd1);

        // Directed table.
        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 25; i++) begin
            rv.op        = 2'($urandom_range(0, 2));
            rv.addr      = 7'($urandom);
            rv.data      = $urandom;
            rv.req_wait  = $urandom_range(0, 9);
            rv.resp_wait = $urandom_range(0, 9);
            sel          = $urandom_range(0, 2);
            rv.d_resp    = (sel == 0) ? 2'd0 : (sel == 1) ? 2'd2 : 2'd3;
            rv.d_data    = $urandom;
            rv.hold      = $urandom_range(0, 3);
            m            = ref_resp(rv.req_wait, rv.resp_wait, rv.d_resp, rv.d_data);
            rv.exp_resp  = m[33:32];
            rv.exp_data  = m[31:0];
            run_txn(rv);
        end

        // Reset asserted while waiting for the DMI response.
        host_req_valid = 1'b1;
        host_req_op    = 2'd1;
        host_req_addr  = 7'h2A;
        host_req_data  = 32'h0;
        tick();
        host_req_valid  = 1'b0;
        debug_req_ready = 1'b1;
        tick();
        debug_req_ready = 1'b0;
        chk("pre_rst_in_resp", 64'(debug_resp_ready), 64'd1);
        rst_ni               = 1'b0;
        debug_resp_valid     = 1'b1;
        debug_resp_bits_resp = 2'd0;
        debug_resp_bits_data = 32'h7777_7777;
        #1;
        chk("midrst_valids", 64'({host_resp_valid, debug_req_valid, debug_resp_ready}), 64'd0);
        chk("midrst_host_resp", 64'({host_resp_resp, host_resp_data}), 64'd0);
        chk("midrst_req_bits", 64'({debug_req_bits_addr, debug_req_bits_op, debug_req_bits_data}), 64'd0);
        tick();
        debug_resp_valid = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        chk("midrst_no_resp", 64'(host_resp_valid), 64'd0);
        chk("midrst_ready", 64'(host_req_ready), 64'd1);
        run_txn(vecs[1]);

        // Exit command, then reset clears it and normal service resumes.
        send_exit(32'h0000_0005, 32'h0000_000B);
        rst_ni = 1'b0;
        #1;
        chk("exit_cleared", 64'(exit_w), 64'd0);
        tick();
        do_reset();
        run_txn(vecs[2]);
        send_exit(32'h8000_0002, 32'h0000_0005);

        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
